// File: rtl/d2l_pkg.sv
// Shared D2L definitions: FSM state encoding, line/pair ordering and the
// round-robin slot helper used by the link arbiter and the receive slave.
package d2l_pkg;

    localparam logic [2:0] D2L_ST_IDLE   = 3'd0;
    localparam logic [2:0] D2L_ST_SELECT = 3'd1;
    localparam logic [2:0] D2L_ST_SHIFT  = 3'd2;
    localparam logic [2:0] D2L_ST_TAIL   = 3'd3;
    localparam logic [2:0] D2L_ST_GAP    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = D2L_ST_IDLE,
        ST_SELECT = D2L_ST_SELECT,
        ST_SHIFT  = D2L_ST_SHIFT,
        ST_TAIL   = D2L_ST_TAIL,
        ST_GAP    = D2L_ST_GAP
    } d2l_state_e;

    // Each pair is sent MSB-first; line 1 carries the higher bit of the pair.
    localparam int D2L_LINE1_BIT = 1;
    localparam int D2L_LINE0_BIT = 0;

    function automatic int d2l_rr_slot(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/d2l_link_arbiter_if.sv
// Requester/link bundle of the D2L link arbiter; master = arbiter side,
// slave = producers plus the D2L receive pins.
interface d2l_link_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4
);
    // Handshake: req[i] is a level request; data_in slice i must be stable
    // while req[i] is high. grant[i] is a one-cycle pulse meaning the word
    // was latched, after which the producer may change data or drop req[i].
    // done[i] pulses once when that frame has fully left the link.
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;
    logic                          OutLine0;
    logic                          OutLine1;
    logic                          CS;

    modport master (
        input  req, data_in,
        output grant, done, busy, OutLine0, OutLine1, CS
    );

    modport slave (
        output req, data_in,
        input  grant, done, busy, OutLine0, OutLine1, CS
    );

endinterface

// File: rtl/d2l_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr by default,
// lowest-index fixed priority when D2L_ARB_FIXED_PRIO_EN is defined.
module d2l_rr_arbiter
    import d2l_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    // Loops run downward so the last hit, i.e. the first in search order, wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef D2L_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'(d2l_rr_slot(int'(ptr), k, NUM_REQ))]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(d2l_rr_slot(int'(ptr), k, NUM_REQ));
            end
        end
`endif
    end

    assign win_onehot = win_valid ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/d2l_link_arbiter.sv
// D2L transmit controller: arbitrates NUM_REQ producers onto one two-wire link.
// Define D2L_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module d2l_link_arbiter
    import d2l_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                sclk,
    input  logic                rstn,
    d2l_link_arbiter_if.master  bus,
    output d2l_state_e          dbg_state
);

    localparam int DC     = DATA_WIDTH / 2;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(DC + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

    d2l_state_e              state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]        cnt;
    logic [GCNT_W-1:0]       gcnt;
    logic [IDX_W-1:0]        cur;
    logic [IDX_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      grant_q;
    logic [NUM_REQ-1:0]      done_q;
    logic                    busy_q;
    logic                    line0_q;
    logic                    line1_q;
    logic                    cs_q;

    logic [NUM_REQ-1:0]      win_onehot;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;
    logic [1:0]              head_pair;

    d2l_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    assign head_pair = shreg[DATA_WIDTH-1 -: 2];

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            cur     <= '0;
            ptr     <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            line0_q <= 1'b0;
            line1_q <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        shreg   <= bus.data_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                        cur     <= win_idx;
                        ptr     <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                        grant_q <= win_onehot;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    line1_q <= head_pair[D2L_LINE1_BIT];
                    line0_q <= head_pair[D2L_LINE0_BIT];
                    shreg   <= shreg << 2;
                    cnt     <= CNT_W'(1);
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // cnt is the index of the pair being driven this edge.
                    if (cnt == CNT_W'(DC)) begin
                        line1_q <= 1'b0;
                        line0_q <= 1'b0;
                        state   <= ST_TAIL;
                    end else begin
                        line1_q <= head_pair[D2L_LINE1_BIT];
                        line0_q <= head_pair[D2L_LINE0_BIT];
                        shreg   <= shreg << 2;
                        cnt     <= cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    cs_q   <= 1'b1;
                    done_q <= NUM_REQ'(1) << cur;
                    gcnt   <= GCNT_W'(GAP_CYCLES - 1);
                    state  <= ST_GAP;
                end
                ST_GAP: begin
                    if (gcnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.OutLine0 = line0_q;
    assign bus.OutLine1 = line1_q;
    assign bus.CS       = cs_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_d2l_link_arbiter.sv
// Bench for d2l_link_arbiter: frame-level reference model (winner choice,
// expected word queue, link timing) plus a negedge-sampling slave model.
module tb_d2l_link_arbiter;
    import d2l_pkg::*;

    localparam int DW  = 64;
    localparam int NR  = 4;
    localparam int GAP = 2;
    localparam int DC  = DW / 2;
    localparam int IW  = $clog2(NR);

    logic       sclk;
    logic       rstn;
    d2l_state_e dbg_state;

    int total;
    int bad;
    int exp_ptr;
    logic [DW-1:0] exp_q[$];
    int            exp_idx_q[$];

    d2l_link_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    d2l_link_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rstn = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge sclk);
        rstn = 1'b1;
        exp_ptr = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_winner(input logic [NR-1:0] r, input int p);
`ifdef D2L_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (r[IW'(i)]) return i + (p * 0);
`else
        for (int k = 0; k < NR; k++) if (r[IW'((p + k) % NR)]) return (p + k) % NR;
`endif
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_word(input int i, input logic [DW-1:0] w);
        bus.data_in[i*DW +: DW] = w;
    endtask

    // Predicts the next frame, then watches the link like the receive slave.
    task automatic observe_frame(input bit drop, input int raise_at, input int raise_idx,
                                 output int gidx, output logic [DW-1:0] word, output int lat,
                                 output int wait_n, output int cs_low_n, output logic [1:0] tail_pair,
                                 output logic [NR-1:0] done_v, output int xgrants, output bit timeout);
        int pred;
        bit got;
        pred = model_winner(bus.req, exp_ptr);
        exp_idx_q.push_back(pred);
        exp_q.push_back((pred >= 0) ? bus.data_in[pred*DW +: DW] : '0);
`ifndef D2L_ARB_FIXED_PRIO_EN
        exp_ptr = (pred + 1) % NR;
`endif
        gidx = -1; word = '0; lat = 0; wait_n = 0; cs_low_n = 0;
        tail_pair = 2'b11; done_v = '0; xgrants = 0; timeout = 1'b0;
        @(negedge sclk);
        while (bus.grant == '0 && wait_n < 200) begin
            wait_n++;
            @(negedge sclk);
        end
        if (bus.grant == '0) begin
            timeout = 1'b1;
            return;
        end
        for (int i = 0; i < NR; i++) if (bus.grant[IW'(i)]) gidx = (gidx == -1) ? i : -2;
        if (!bus.CS) cs_low_n++;
        if (gidx >= 0) begin
            set_word(gidx, rand_word());
            if (drop) bus.req[IW'(gidx)] = 1'b0;
        end
        for (int i = 0; i < DC; i++) begin
            @(negedge sclk);
            lat++;
            word = {word[DW-3:0], bus.OutLine1, bus.OutLine0};
            if (!bus.CS) cs_low_n++;
            if (bus.grant != '0) xgrants++;
            done_v |= bus.done;
            if (i == raise_at) bus.req[IW'(raise_idx)] = 1'b1;
        end
        @(negedge sclk);
        lat++;
        tail_pair = {bus.OutLine1, bus.OutLine0};
        if (!bus.CS) cs_low_n++;
        if (bus.grant != '0) xgrants++;
        done_v |= bus.done;
        got = 1'b0;
        while (!got && lat < DC + 20) begin
            @(negedge sclk);
            lat++;
            if (bus.grant != '0) xgrants++;
            if (bus.done != '0) begin
                got = 1'b1;
                done_v |= bus.done;
            end
        end
        if (!got) timeout = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge sclk);
        total++; if (bus.CS !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b want 1", bus.CS); end
        total++; if ({bus.OutLine1, bus.OutLine0} !== 2'b00) begin bad++; $display("FAIL reset_lines: got %b want 00", {bus.OutLine1, bus.OutLine0}); end
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
        total++; if (bus.done !== '0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        rstn = 1'b1;
        exp_ptr = 0;
        repeat (5) @(negedge sclk);
        total++; if (bus.busy !== 1'b0 || bus.CS !== 1'b1 || bus.grant !== '0) begin
            bad++; $display("FAIL idle_no_req: busy=%b cs=%b grant=%b want 0/1/0", bus.busy, bus.CS, bus.grant);
        end
    endtask

    task automatic test_single_frame();
        int gidx, lat, wn, csl, xg, pred;
        logic [DW-1:0] w, ew;
        logic [1:0] tp;
        logic [NR-1:0] dv;
        bit to;
        set_word(0, 64'hF0E1_D2C3_B4A5_9687);
        bus.req = 4'b0001;
        observe_frame(1'b1, -1, 0, gidx, w, lat, wn, csl, tp, dv, xg, to);
        pred = exp_idx_q.pop_front();
        ew = exp_q.pop_front();
        total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", to); end
        total++; if (gidx !== pred) begin bad++; $display("FAIL single_grant: got %0d want %0d", gidx, pred); end
        total++; if (w[DW-1 -: 8] !== 8'hF0) begin bad++; $display("FAIL single_first_pairs: got %h want f0", w[DW-1 -: 8]); end
        total++; if (w !== ew) begin bad++; $display("FAIL single_word: got %h want %h", w, ew); end
        total++; if (lat !== DC + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, DC + 2); end
        total++; if (csl !== DC + 2) begin bad++; $display("FAIL single_cs_low: got %0d want %0d", csl, DC + 2); end
        total++; if (tp !== 2'b00) begin bad++; $display("FAIL single_tail_lines: got %b want 00", tp); end
        total++; if (dv !== NR'(1) << pred) begin bad++; $display("FAIL single_done: got %b want %b", dv, NR'(1) << pred); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap: got %b want 1", bus.busy); end
        repeat (GAP + 2) @(negedge sclk);
        total++; if (bus.busy !== 1'b0 || bus.CS !== 1'b1) begin
            bad++; $display("FAIL single_back_idle: busy=%b cs=%b want 0/1", bus.busy, bus.CS);
        end
    endtask

    task automatic test_round_robin();
        int gidx, lat, wn, csl, xg, pred;
        logic [DW-1:0] w, ew;
        logic [1:0] tp;
        logic [NR-1:0] dv;
        bit to;
        apply_reset();
        for (int i = 0; i < NR; i++) set_word(i, rand_word());
        bus.req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            observe_frame(1'b0, -1, 0, gidx, w, lat, wn, csl, tp, dv, xg, to);
            pred = exp_idx_q.pop_front();
            ew = exp_q.pop_front();
            total++; if (to !== 1'b0) begin bad++; $display("FAIL rr_timeout[%0d]: got %b want 0", f, to); end
            total++; if (gidx !== pred) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", f, gidx, pred); end
            total++; if (w !== ew) begin bad++; $display("FAIL rr_word[%0d]: got %h want %h", f, w, ew); end
            total++; if (dv !== NR'(1) << pred) begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", f, dv, NR'(1) << pred); end
            if (f > 0) begin
                total++; if (wn !== GAP) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want %0d", f, wn, GAP); end
            end
        end
        bus.req = '0;
        repeat (GAP + 4) @(negedge sclk);
    endtask

    task automatic test_late_request();
        int gidx, lat, wn, csl, xg, pred;
        logic [DW-1:0] w, ew;
        logic [1:0] tp;
        logic [NR-1:0] dv;
        bit to;
        set_word(3, rand_word());
        set_word(1, rand_word());
        bus.req = 4'b1000;
        observe_frame(1'b1, 5, 1, gidx, w, lat, wn, csl, tp, dv, xg, to);
        pred = exp_idx_q.pop_front();
        ew = exp_q.pop_front();
        total++; if (gidx !== pred) begin bad++; $display("FAIL late_first_grant: got %0d want %0d", gidx, pred); end
        total++; if (xg !== 0) begin bad++; $display("FAIL late_grant_in_frame: got %0d want 0", xg); end
        total++; if (w !== ew) begin bad++; $display("FAIL late_first_word: got %h want %h", w, ew); end
        observe_frame(1'b1, -1, 0, gidx, w, lat, wn, csl, tp, dv, xg, to);
        pred = exp_idx_q.pop_front();
        ew = exp_q.pop_front();
        total++; if (to !== 1'b0) begin bad++; $display("FAIL late_timeout: got %b want 0", to); end
        total++; if (gidx !== pred) begin bad++; $display("FAIL late_second_grant: got %0d want %0d", gidx, pred); end
        total++; if (wn !== GAP) begin bad++; $display("FAIL late_wait: got %0d want %0d", wn, GAP); end
        total++; if (w !== ew) begin bad++; $display("FAIL late_second_word: got %h want %h", w, ew); end
        total++; if (lat !== DC + 2) begin bad++; $display("FAIL late_latency: got %0d want %0d", lat, DC + 2); end
        repeat (GAP + 4) @(negedge sclk);
    endtask

    task automatic test_reset_mid_frame();
        int gidx, lat, wn, csl, xg, pred, n;
        logic [DW-1:0] w, ew;
        logic [1:0] tp;
        logic [NR-1:0] dv, seen_done;
        bit to;
        apply_reset();
        for (int i = 0; i < NR; i++) set_word(i, rand_word());
        bus.req = 4'b0110;
        pred = model_winner(bus.req, exp_ptr);
        n = 0;
        @(negedge sclk);
        while (bus.grant == '0 && n < 100) begin
            n++;
            @(negedge sclk);
        end
        total++; if (bus.grant !== NR'(1) << pred) begin bad++; $display("FAIL mid_grant: got %b want %b", bus.grant, NR'(1) << pred); end
        bus.req[IW'(pred)] = 1'b0;
        seen_done = '0;
        repeat (11) begin
            @(negedge sclk);
            seen_done |= bus.done;
        end
        total++; if (bus.CS !== 1'b0) begin bad++; $display("FAIL mid_cs_before: got %b want 0", bus.CS); end
        rstn = 1'b0;
        #1;
        total++; if (bus.CS !== 1'b1 || bus.busy !== 1'b0 || {bus.OutLine1, bus.OutLine0} !== 2'b00) begin
            bad++; $display("FAIL mid_reset_outputs: cs=%b busy=%b lines=%b want 1/0/00", bus.CS, bus.busy, {bus.OutLine1, bus.OutLine0});
        end
        repeat (2) begin
            @(negedge sclk);
            seen_done |= bus.done;
        end
        rstn = 1'b1;
        exp_ptr = 0;
        total++; if (seen_done !== '0) begin bad++; $display("FAIL mid_no_done: got %b want 0", seen_done); end
        observe_frame(1'b1, -1, 0, gidx, w, lat, wn, csl, tp, dv, xg, to);
        pred = exp_idx_q.pop_front();
        ew = exp_q.pop_front();
        total++; if (to !== 1'b0) begin bad++; $display("FAIL mid_timeout: got %b want 0", to); end
        total++; if (gidx !== pred) begin bad++; $display("FAIL mid_fresh_grant: got %0d want %0d", gidx, pred); end
        total++; if (w !== ew) begin bad++; $display("FAIL mid_fresh_word: got %h want %h", w, ew); end
        total++; if (csl !== DC + 2) begin bad++; $display("FAIL mid_fresh_cs_low: got %0d want %0d", csl, DC + 2); end
    endtask

    task automatic test_random_frames();
        int gidx, lat, wn, csl, xg, pred;
        logic [DW-1:0] w, ew;
        logic [1:0] tp;
        logic [NR-1:0] dv;
        bit to;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NR; i++) set_word(i, rand_word());
            bus.req = NR'($urandom_range(1, (1 << NR) - 1));
            observe_frame(1'b1, -1, 0, gidx, w, lat, wn, csl, tp, dv, xg, to);
            pred = exp_idx_q.pop_front();
            ew = exp_q.pop_front();
            total++; if (to !== 1'b0) begin bad++; $display("FAIL rand_timeout[%0d]: got %b want 0", it, to); end
            total++; if (gidx !== pred) begin bad++; $display("FAIL rand_grant[%0d]: got %0d want %0d", it, gidx, pred); end
            total++; if (w !== ew) begin bad++; $display("FAIL rand_word[%0d]: got %h want %h", it, w, ew); end
            total++; if (lat !== DC + 2) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, DC + 2); end
            total++; if (tp !== 2'b00) begin bad++; $display("FAIL rand_tail[%0d]: got %b want 00", it, tp); end
            if (it > 0) begin
                total++; if (wn !== GAP) begin bad++; $display("FAIL rand_gap[%0d]: got %0d want %0d", it, wn, GAP); end
            end
        end
        bus.req = '0;
        repeat (GAP + 4) @(negedge sclk);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        total = 0;
        bad = 0;
        exp_ptr = 0;
        rstn = 1'b0;
        bus.req = '0;
        bus.data_in = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_late_request();
        test_reset_mid_frame();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
